// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the core's single external memory port between the I-cache refill
// path (I-side) and the data-memory path (D-side). One owner at a time,
// round-robin on ties, the grant is held until the memory acknowledges, and
// the D-side can hold the bus across a read-modify-write pair with
// i_dm_lock so that no fetch is interleaved between the two halves.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-low reset
//   i_ic_req/i_ic_addr  I-side refill request and word address
//   o_ic_data           I-side read data (meaningful with o_ic_ready)
//   o_ic_ready          I-side transfer complete, 1-cycle pulse
//   i_dm_rd/i_dm_wr     D-side read / write request
//   i_dm_addr/i_dm_wdata/i_dm_be  D-side address, write data, byte enables
//   i_dm_lock           keep the bus on the D-side after the current transfer
//   o_dm_rdata          D-side read data (meaningful with o_dm_ready)
//   o_dm_ready          D-side transfer complete, 1-cycle pulse
//   o_mem_req/we/addr/wdata/be   memory request side
//   i_mem_rdata/i_mem_ack        memory response side
//   o_grant             current owner: 00 none, 01 I-side, 10 D-side
//   o_state             debug view of the arbiter state
//                       (00 IDLE, 01 GNT_I, 10 GNT_D, 11 LOCKED)
//
// Handshake: a requester raises its request (i_ic_req, or i_dm_rd/i_dm_wr)
// together with stable address/data and holds it until the matching ready
// pulse; the transfer completes in exactly the cycle the ready is high, and
// the requester may present a new request from the following cycle. On the
// memory side o_mem_req is held with stable address/data until the single
// cycle i_mem_ack pulse; that same cycle completes the transfer.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,

    input  logic            i_ic_req,
    input  logic [XLEN-1:0] i_ic_addr,
    output logic [XLEN-1:0] o_ic_data,
    output logic            o_ic_ready,

    input  logic            i_dm_rd,
    input  logic            i_dm_wr,
    input  logic [XLEN-1:0] i_dm_addr,
    input  logic [XLEN-1:0] i_dm_wdata,
    input  logic [3:0]      i_dm_be,
    input  logic            i_dm_lock,
    output logic [XLEN-1:0] o_dm_rdata,
    output logic            o_dm_ready,

    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_be,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_mem_ack,

    output logic [1:0]      o_grant,
    output logic [1:0]      o_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_I  = 2'b01,
        GNT_D  = 2'b10,
        LOCKED = 2'b11
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    state_t state;

    // Side that completed the most recent transfer: 0 = I, 1 = D.
    // Resets to I so that the first tie after reset goes to the D-side.
    logic   last_d;

    logic   d_req;
    logic   own_i;
    logic   own_d;

    assign d_req = i_dm_rd | i_dm_wr;

    // -----------------------------------------------------------------------
    // Arbitration FSM. o_grant and o_mem_req are registered alongside the
    // state so both come straight out of flops.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            o_grant   <= GRANT_NONE;
            o_mem_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // I wins when it is alone, or on a tie when D went last.
                    if (i_ic_req && (!d_req || last_d)) begin
                        state     <= GNT_I;
                        o_grant   <= GRANT_I;
                        o_mem_req <= 1'b1;
                    end else if (d_req) begin
                        state     <= GNT_D;
                        o_grant   <= GRANT_D;
                        o_mem_req <= 1'b1;
                    end
                end

                GNT_I: begin
                    if (i_mem_ack) begin
                        state     <= IDLE;
                        last_d    <= 1'b0;
                        o_grant   <= GRANT_NONE;
                        o_mem_req <= 1'b0;
                    end
                end

                GNT_D: begin
                    if (i_mem_ack) begin
                        last_d    <= 1'b1;
                        o_mem_req <= 1'b0;
                        // A D-side that abandoned its request has nothing
                        // to lock for, so it always falls back to IDLE.
                        if (i_dm_lock && d_req) begin
                            state   <= LOCKED;
                            o_grant <= GRANT_D;
                        end else begin
                            state   <= IDLE;
                            o_grant <= GRANT_NONE;
                        end
                    end
                end

                LOCKED: begin
                    // Bus reserved for the D-side; I requests are not looked
                    // at until the lock is released with no D request pending.
                    if (d_req) begin
                        state     <= GNT_D;
                        o_grant   <= GRANT_D;
                        o_mem_req <= 1'b1;
                    end else if (!i_dm_lock) begin
                        state   <= IDLE;
                        o_grant <= GRANT_NONE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    o_grant   <= GRANT_NONE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // The memory-side mux follows the registered owner. LOCKED owns nothing
    // on the memory port, so its outputs read as idle (all zero).
    assign own_i = (state == GNT_I);
    assign own_d = (state == GNT_D);

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = 4'b0000;
        if (own_i) begin
            o_mem_addr = i_ic_addr;
            o_mem_be   = 4'b1111;
        end else if (own_d) begin
            // With both rd and wr raised the write takes precedence.
            o_mem_we    = i_dm_wr;
            o_mem_addr  = i_dm_addr;
            o_mem_wdata = i_dm_wdata;
            o_mem_be    = i_dm_wr ? i_dm_be : 4'b1111;
        end
    end

    // Ready pulses only to the current owner and only while it still holds
    // its request; an ack for an abandoned request is silently dropped, and
    // an ack outside GNT_I/GNT_D never reaches either side.
    assign o_ic_ready = own_i & i_mem_ack & i_ic_req;
    assign o_dm_ready = own_d & i_mem_ack & d_req;

    // Read data is a straight pass-through; it only means something while
    // the corresponding ready is high.
    assign o_ic_data  = i_mem_rdata;
    assign o_dm_rdata = i_mem_rdata;

    assign o_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. Requesters are fed from per-side transaction
// queues and hold each request until its ready pulse; a memory responder
// acks after a programmable number of request cycles. A transaction-level
// model (who owns the bus, whether it is reserved for D, who went last)
// predicts every output each cycle, and a completion scoreboard (exp_q)
// holds the hand-written order in which sides must finish.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam logic [1:0] OWN_I = 2'b01;
    localparam logic [1:0] OWN_D = 2'b10;

    // ---------------- clock / reset / DUT ----------------
    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic            i_ic_req = 1'b0;
    logic [XLEN-1:0] i_ic_addr = '0;
    logic [XLEN-1:0] o_ic_data;
    logic            o_ic_ready;
    logic            i_dm_rd = 1'b0;
    logic            i_dm_wr = 1'b0;
    logic [XLEN-1:0] i_dm_addr = '0;
    logic [XLEN-1:0] i_dm_wdata = '0;
    logic [3:0]      i_dm_be = '0;
    logic            i_dm_lock = 1'b0;
    logic [XLEN-1:0] o_dm_rdata;
    logic            o_dm_ready;
    logic            o_mem_req;
    logic            o_mem_we;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wdata;
    logic [3:0]      o_mem_be;
    logic [XLEN-1:0] i_mem_rdata = '0;
    logic            i_mem_ack = 1'b0;
    logic [1:0]      o_grant;
    logic [1:0]      o_state;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.XLEN(XLEN)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ic_req    (i_ic_req),
        .i_ic_addr   (i_ic_addr),
        .o_ic_data   (o_ic_data),
        .o_ic_ready  (o_ic_ready),
        .i_dm_rd     (i_dm_rd),
        .i_dm_wr     (i_dm_wr),
        .i_dm_addr   (i_dm_addr),
        .i_dm_wdata  (i_dm_wdata),
        .i_dm_be     (i_dm_be),
        .i_dm_lock   (i_dm_lock),
        .o_dm_rdata  (o_dm_rdata),
        .o_dm_ready  (o_dm_ready),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_be    (o_mem_be),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack),
        .o_grant     (o_grant),
        .o_state     (o_state)
    );

    // ---------------- bench state ----------------
    typedef struct packed {
        logic            rd;
        logic            wr;
        logic            lock;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      be;
    } dm_txn_t;

    logic [XLEN-1:0] ic_q[$];
    dm_txn_t         dm_q[$];
    logic [1:0]      exp_q[$];
    int              ready_cycles[$];
    int              dm_ready_cycles[$];
    logic [1:0]      grant_after_dm_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mem_lat = 0;
    int   wait_cnt = 0;
    bit   stray_ack = 1'b0;
    bit   ic_done = 1'b0;
    bit   dm_done = 1'b0;
    bit   prev_req = 1'b0;
    bit   prev_dm_ready = 1'b0;

    int              ic_present_cyc = 0;
    int              cap_req_cyc = 0;
    int              ic_ready_cyc = 0;
    logic            cap_we = 1'b0;
    logic [3:0]      cap_be = '0;
    logic [XLEN-1:0] cap_addr = '0;
    logic [XLEN-1:0] cap_wdata = '0;
    logic [XLEN-1:0] cap_ic_data = '0;

    // ---------------- behavioural model ----------------
    // m_owner: 0 nobody, 1 I-side, 2 D-side on the memory port.
    int   m_owner = 0;
    bit   m_hold_d = 1'b0;
    bit   m_last_d = 1'b0;

    logic            e_dreq;
    logic [1:0]      e_grant;
    logic            e_req;
    logic            e_we;
    logic [XLEN-1:0] e_addr;
    logic [XLEN-1:0] e_wdata;
    logic [3:0]      e_be;
    logic            e_ic_ready;
    logic            e_dm_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_hold_d = 1'b0;
        m_last_d = 1'b0;
    endtask

    // Advance the model by one clock using the inputs of the ending cycle.
    task automatic model_clock();
        bit dreq;
        dreq = i_dm_rd | i_dm_wr;
        if (m_owner != 0) begin
            if (i_mem_ack) begin
                m_last_d = (m_owner == 2);
                m_hold_d = (m_owner == 2) && i_dm_lock && dreq;
                m_owner  = 0;
            end
        end else if (m_hold_d) begin
            if (dreq) begin
                m_owner  = 2;
                m_hold_d = 1'b0;
            end else if (!i_dm_lock) begin
                m_hold_d = 1'b0;
            end
        end else if (i_ic_req && dreq) begin
            m_owner = m_last_d ? 1 : 2;
        end else if (i_ic_req) begin
            m_owner = 1;
        end else if (dreq) begin
            m_owner = 2;
        end
    endtask

    function automatic logic [XLEN-1:0] mem_image(input logic [XLEN-1:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge i_clk);
        if (i_rst) model_clock();
        cyc++;
        #1;
        if (ic_done) begin
            if (ic_q.size() > 0) ic_q.delete(0);
            ic_done = 1'b0;
        end
        if (dm_done) begin
            if (dm_q.size() > 0) dm_q.delete(0);
            dm_done = 1'b0;
        end
        if (!i_ic_req && ic_q.size() > 0) ic_present_cyc = cyc;
        i_ic_req  = (ic_q.size() > 0);
        i_ic_addr = (ic_q.size() > 0) ? ic_q[0] : '0;
        if (dm_q.size() > 0) begin
            i_dm_rd    = dm_q[0].rd;
            i_dm_wr    = dm_q[0].wr;
            i_dm_lock  = dm_q[0].lock;
            i_dm_addr  = dm_q[0].addr;
            i_dm_wdata = dm_q[0].wdata;
            i_dm_be    = dm_q[0].be;
        end else begin
            i_dm_rd    = 1'b0;
            i_dm_wr    = 1'b0;
            i_dm_lock  = 1'b0;
            i_dm_addr  = '0;
            i_dm_wdata = '0;
            i_dm_be    = '0;
        end
        // Memory responder: ack after mem_lat waiting cycles of o_mem_req.
        if (o_mem_req) begin
            if (wait_cnt >= mem_lat) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = mem_image(o_mem_addr);
                wait_cnt    = 0;
            end else begin
                i_mem_ack   = 1'b0;
                i_mem_rdata = '0;
                wait_cnt++;
            end
        end else begin
            i_mem_ack   = stray_ack;
            i_mem_rdata = stray_ack ? 32'h0BAD_0BAD : '0;
            wait_cnt    = 0;
        end
    endtask

    task automatic push_dm(input logic rd, input logic wr, input logic lock,
                           input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata,
                           input logic [3:0] be);
        dm_txn_t t;
        t.rd = rd; t.wr = wr; t.lock = lock;
        t.addr = addr; t.wdata = wdata; t.be = be;
        dm_q.push_back(t);
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((ic_q.size() > 0 || dm_q.size() > 0 || o_grant != 2'b00) && n < budget) begin
            cycle();
            n++;
        end
        check({name, "_done_in_budget"}, 32'(n < budget), 32'd1);
        cycle();
    endtask

    // ---------------- compare process / scoreboard ----------------
    initial forever begin
        @(negedge i_clk);
        if (i_rst) begin
            e_dreq     = i_dm_rd | i_dm_wr;
            e_grant    = (m_owner == 1) ? OWN_I : ((m_owner == 2 || m_hold_d) ? OWN_D : 2'b00);
            e_req      = (m_owner != 0);
            e_we       = (m_owner == 2) && i_dm_wr;
            e_addr     = (m_owner == 1) ? i_ic_addr : ((m_owner == 2) ? i_dm_addr : '0);
            e_wdata    = (m_owner == 2) ? i_dm_wdata : '0;
            e_be       = (m_owner == 1) ? 4'b1111 :
                         ((m_owner == 2) ? (i_dm_wr ? i_dm_be : 4'b1111) : 4'b0000);
            e_ic_ready = (m_owner == 1) && i_mem_ack && i_ic_req;
            e_dm_ready = (m_owner == 2) && i_mem_ack && e_dreq;

            check("grant",     32'(o_grant),    32'(e_grant));
            check("mem_req",   32'(o_mem_req),  32'(e_req));
            check("mem_we",    32'(o_mem_we),   32'(e_we));
            check("mem_addr",  o_mem_addr,      e_addr);
            check("mem_wdata", o_mem_wdata,     e_wdata);
            check("mem_be",    32'(o_mem_be),   32'(e_be));
            check("ic_ready",  32'(o_ic_ready), 32'(e_ic_ready));
            check("dm_ready",  32'(o_dm_ready), 32'(e_dm_ready));
            if (o_ic_ready) check("ic_data",  o_ic_data,  i_mem_rdata);
            if (o_dm_ready) check("dm_rdata", o_dm_rdata, i_mem_rdata);

            // Completion order against the hand-written expectation.
            if (o_ic_ready || o_dm_ready) begin
                if (exp_q.size() == 0)
                    check("ready_unexpected", 32'({o_dm_ready, o_ic_ready}), 32'd0);
                else
                    check("ready_owner", 32'({o_dm_ready, o_ic_ready}), 32'(exp_q.pop_front()));
                ready_cycles.push_back(cyc);
            end

            if (o_mem_req && !prev_req) begin
                cap_req_cyc = cyc;
                cap_we      = o_mem_we;
                cap_be      = o_mem_be;
                cap_addr    = o_mem_addr;
                cap_wdata   = o_mem_wdata;
            end
            prev_req = o_mem_req;

            if (prev_dm_ready) grant_after_dm_q.push_back(o_grant);
            prev_dm_ready = o_dm_ready;

            if (o_ic_ready) begin
                ic_done      = 1'b1;
                cap_ic_data  = o_ic_data;
                ic_ready_cyc = cyc;
            end
            if (o_dm_ready) begin
                dm_done = 1'b1;
                dm_ready_cycles.push_back(cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int ready_before;

        // Reset state.
        model_reset();
        repeat (3) cycle();
        check("rst_grant",   32'(o_grant),    32'd0);
        check("rst_mem_req", 32'(o_mem_req),  32'd0);
        check("rst_mem_we",  32'(o_mem_we),   32'd0);
        check("rst_addr",    o_mem_addr,      32'd0);
        check("rst_ready",   32'({o_ic_ready, o_dm_ready}), 32'd0);
        i_rst = 1'b1;
        cycle();

        // Single I read, memory acks 2 cycles after the request rises.
        mem_lat = 2;
        ic_q.push_back(32'h0000_0100);
        exp_q.push_back(OWN_I);
        run_until_idle("ic_read", 40);
        check("ic_read_latency", 32'(cap_req_cyc - ic_present_cyc), 32'd1);
        check("ic_read_ack_gap", 32'(ic_ready_cyc - cap_req_cyc), 32'd2);
        check("ic_read_data",    cap_ic_data,  32'hDEAD_BEEF);
        check("ic_read_addr",    cap_addr,     32'h0000_0100);
        check("ic_read_be",      32'(cap_be),  32'hF);
        check("ic_read_we",      32'(cap_we),  32'd0);

        // D write with partial byte enables.
        mem_lat = 1;
        push_dm(1'b0, 1'b1, 1'b0, 32'h0000_2004, 32'h0000_0055, 4'b0010);
        exp_q.push_back(OWN_D);
        run_until_idle("dm_write", 40);
        check("dm_write_we",    32'(cap_we),  32'd1);
        check("dm_write_be",    32'(cap_be),  32'b0010);
        check("dm_write_addr",  cap_addr,     32'h0000_2004);
        check("dm_write_wdata", cap_wdata,    32'h0000_0055);

        // rd and wr raised together: the write wins.
        push_dm(1'b1, 1'b1, 1'b0, 32'h0000_2008, 32'h0000_0077, 4'b1000);
        exp_q.push_back(OWN_D);
        run_until_idle("dm_rdwr", 40);
        check("dm_rdwr_we", 32'(cap_we), 32'd1);
        check("dm_rdwr_be", 32'(cap_be), 32'b1000);

        // Asynchronous reset in the middle of a D transfer.
        mem_lat = 6;
        push_dm(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0, 4'b0000);
        exp_q.push_back(OWN_D);
        n = 0;
        while (!o_mem_req && n < 10) begin
            cycle();
            n++;
        end
        check("rst_setup_req", 32'(o_mem_req), 32'd1);
        cycle();
        @(negedge i_clk);
        #2;
        i_rst = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(o_mem_req),  32'd0);
        check("async_rst_grant",   32'(o_grant),    32'd0);
        check("async_rst_we",      32'(o_mem_we),   32'd0);
        check("async_rst_addr",    o_mem_addr,      32'd0);
        check("async_rst_wdata",   o_mem_wdata,     32'd0);
        check("async_rst_ready",   32'({o_ic_ready, o_dm_ready}), 32'd0);
        check("async_rst_state",   32'(o_state),    32'd0);
        ic_q.delete();
        dm_q.delete();
        exp_q.delete();
        ic_done  = 1'b0;
        dm_done  = 1'b0;
        prev_req = 1'b0;
        prev_dm_ready = 1'b0;
        model_reset();
        repeat (2) cycle();
        i_rst = 1'b1;

        // Contention: both sides keep requesting, 1-wait memory.
        // First tie after reset goes to D, then strict alternation.
        mem_lat = 1;
        ready_cycles.delete();
        for (int i = 0; i < 3; i++) begin
            ic_q.push_back(32'h0000_0500 + 32'(4 * i));
            push_dm(1'b1, 1'b0, 1'b0, 32'h0000_0600 + 32'(4 * i), 32'h0, 4'b0000);
            exp_q.push_back(OWN_D);
            exp_q.push_back(OWN_I);
        end
        run_until_idle("contention", 80);
        check("contention_count", 32'(ready_cycles.size()), 32'd6);
        if (ready_cycles.size() == 6)
            check("contention_span", 32'(ready_cycles[5] - ready_cycles[0]), 32'd15);

        // Lock: D read with lock, then D write, while I waits throughout.
        mem_lat = 0;
        ready_cycles.delete();
        dm_ready_cycles.delete();
        grant_after_dm_q.delete();
        ic_q.push_back(32'h0000_0300);
        push_dm(1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 4'b0000);
        push_dm(1'b0, 1'b1, 1'b0, 32'h0000_0404, 32'h0000_00A5, 4'b1111);
        exp_q.push_back(OWN_D);
        exp_q.push_back(OWN_D);
        exp_q.push_back(OWN_I);
        run_until_idle("lock", 60);
        check("lock_dm_count", 32'(dm_ready_cycles.size()), 32'd2);
        if (dm_ready_cycles.size() == 2)
            check("lock_dm_gap", 32'(dm_ready_cycles[1] - dm_ready_cycles[0]), 32'd2);
        check("lock_hold_count", 32'(grant_after_dm_q.size()), 32'd2);
        if (grant_after_dm_q.size() == 2) begin
            check("lock_grant_held",    32'(grant_after_dm_q[0]), 32'(OWN_D));
            check("lock_grant_release", 32'(grant_after_dm_q[1]), 32'd0);
        end
        check("lock_i_after_d", 32'(ic_ready_cyc - dm_ready_cycles[dm_ready_cycles.size() - 1]), 32'd2);

        // Stray ack while idle: no ready, state stays IDLE.
        ready_before = ready_cycles.size();
        cycle();
        stray_ack = 1'b1;
        cycle();
        stray_ack = 1'b0;
        cycle();
        check("stray_grant",  32'(o_grant), 32'd0);
        check("stray_state",  32'(o_state), 32'd0);
        check("stray_no_ready", 32'(ready_cycles.size()), 32'(ready_before));

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
